// File: rtl/namuru_pkg.sv
// Shared definitions for the Namuru sample-clock timebase.
package namuru_pkg;

  localparam int CNT_W_DEF = 24;

  // rstn is asserted low.
  localparam logic RSTN_ACTIVE = 1'b0;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/namuru_divider.sv
// Reloading down-counter with a registered flag that is high while the count sits at zero.
module namuru_divider
  import namuru_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] divide,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_nxt;

  // divide is only looked at on reload, so mid-period changes never alter the running period.
  always_comb begin
    count_nxt = count - 1'b1;
    if (count == '0) begin
      count_nxt = divide;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= divide;
      zero  <= 1'b0;
    end else begin
      count <= count_nxt;
      zero  <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/namuru_time_base.sv
// TIC / ACCUM strobe generator for the Namuru correlator sample-clock domain.
// Define NAMURU_TIME_BASE_PPS_EN to add the 1PPS counter and pps output.
module namuru_time_base
  import namuru_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef NAMURU_TIME_BASE_PPS_EN
  ,
  parameter int PPS_TICS = 10
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sw_rst,
  input  logic [CNT_W-1:0] tic_divide,
  input  logic [CNT_W-1:0] accum_divide,
  output logic             pre_tic_enable,
  output logic             tic_enable,
  output logic             accum_enable,
  output logic [CNT_W-1:0] tic_count,
  output logic [CNT_W-1:0] accum_count
`ifdef NAMURU_TIME_BASE_PPS_EN
  ,
  output logic             pps
`endif
);

  logic clr;
  logic tic_zero;
  logic accum_zero;

  assign clr = (rstn == RSTN_ACTIVE) || sw_rst;

  namuru_divider #(.W(CNT_W)) u_tic (
    .clk    (clk),
    .clr    (clr),
    .divide (tic_divide),
    .count  (tic_count),
    .zero   (tic_zero)
  );

  namuru_divider #(.W(CNT_W)) u_accum (
    .clk    (clk),
    .clr    (clr),
    .divide (accum_divide),
    .count  (accum_count),
    .zero   (accum_zero)
  );

  // The zero flag is the early warning; both delivered strobes lag their own zero by one cycle.
  assign pre_tic_enable = tic_zero;

  always_ff @(posedge clk) begin
    if (clr) begin
      tic_enable   <= 1'b0;
      accum_enable <= 1'b0;
    end else begin
      tic_enable   <= pre_tic_enable;
      accum_enable <= accum_zero;
    end
  end

`ifdef NAMURU_TIME_BASE_PPS_EN
  localparam int PPS_W = (PPS_TICS > 1) ? $clog2(PPS_TICS) : 1;
  localparam logic [PPS_W-1:0] PPS_LAST = PPS_W'(PPS_TICS - 1);

  logic [PPS_W-1:0] pps_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      pps_cnt <= '0;
      pps     <= 1'b0;
    end else begin
      pps <= tic_enable && (pps_cnt == PPS_LAST);
      if (tic_enable) begin
        pps_cnt <= (pps_cnt == PPS_LAST) ? '0 : pps_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_namuru_time_base.sv
// Self-checking bench for namuru_time_base: cycle model feeds a scoreboard, plus fixed-value checks.
module tb_namuru_time_base;
  import namuru_pkg::*;

  localparam int PPS_TICS = 10;
`ifdef NAMURU_TIME_BASE_PPS_EN
  localparam bit HAS_PPS = 1'b1;
`else
  localparam bit HAS_PPS = 1'b0;
`endif

  typedef struct packed {
    logic pre;
    logic ten;
    logic aen;
    logic pps;
    cnt_t tc;
    cnt_t ac;
  } obs_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sw_rst = 1'b0;
  cnt_t tic_divide = 24'd4;
  cnt_t accum_divide = 24'd9;
  logic pre_tic_enable, tic_enable, accum_enable;
  cnt_t tic_count, accum_count;
  logic pps_obs;

  int checks = 0;
  int failures = 0;
  obs_t sb[$];
  obs_t got, exp;

  cnt_t m_tic, m_acc;
  logic m_pre, m_az, m_ten, m_aen, m_pps;
  int   m_pcnt;

`ifdef NAMURU_TIME_BASE_PPS_EN
  logic pps;
  assign pps_obs = pps;
`else
  assign pps_obs = 1'b0;
`endif

  namuru_time_base #(
    .CNT_W(CNT_W_DEF)
`ifdef NAMURU_TIME_BASE_PPS_EN
    , .PPS_TICS(PPS_TICS)
`endif
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sw_rst         (sw_rst),
    .tic_divide     (tic_divide),
    .accum_divide   (accum_divide),
    .pre_tic_enable (pre_tic_enable),
    .tic_enable     (tic_enable),
    .accum_enable   (accum_enable),
    .tic_count      (tic_count),
    .accum_count    (accum_count)
`ifdef NAMURU_TIME_BASE_PPS_EN
    , .pps          (pps)
`endif
  );

  always #5 clk = ~clk;

  // Drives one clock edge, predicts what the outputs should be after it and queues that prediction.
  task automatic cycle(input logic r, input logic s, input cnt_t td, input cnt_t ad);
    logic pre_n, az_n;
    @(negedge clk);
    rstn = r;
    sw_rst = s;
    tic_divide = td;
    accum_divide = ad;
    if (!r || s) begin
      m_tic = td; m_acc = ad;
      m_pre = 1'b0; m_az = 1'b0; m_ten = 1'b0; m_aen = 1'b0; m_pps = 1'b0;
      m_pcnt = 0;
    end else begin
      pre_n = (m_tic == 24'd1) || (m_tic == 24'd0 && td == 24'd0);
      az_n  = (m_acc == 24'd1) || (m_acc == 24'd0 && ad == 24'd0);
      m_pps = m_ten && (m_pcnt == PPS_TICS - 1);
      if (m_ten) m_pcnt = (m_pcnt == PPS_TICS - 1) ? 0 : m_pcnt + 1;
      m_ten = m_pre;
      m_aen = m_az;
      m_pre = pre_n;
      m_az  = az_n;
      m_tic = (m_tic == 24'd0) ? td : cnt_t'(m_tic - 1'b1);
      m_acc = (m_acc == 24'd0) ? ad : cnt_t'(m_acc - 1'b1);
    end
    sb.push_back({m_pre, m_ten, m_aen, m_pps & HAS_PPS, m_tic, m_acc});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 24'd4, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL reset_sb: got %h expected %h", got, exp);
      end
    end
    checks++;
    if (tic_count !== 24'd4 || accum_count !== 24'd9 ||
        {pre_tic_enable, tic_enable, accum_enable, pps_obs} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_values: got tic=%0d acc=%0d strobes=%b%b%b%b expected 4 9 0000",
               tic_count, accum_count, pre_tic_enable, tic_enable, accum_enable, pps_obs);
    end
  endtask

  task automatic test_basic();
    cnt_t seq [6] = '{24'd3, 24'd2, 24'd1, 24'd0, 24'd4, 24'd3};
    int n_pre = 0, n_ten = 0, n_aen = 0, first_pre = 0, first_ten = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 24'd4, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL basic_sb edge %0d: got %h expected %h", i, got, exp);
      end
      if (i <= 6) begin
        checks++;
        if (tic_count !== seq[i-1]) begin
          failures++;
          $display("[TB] FAIL basic_seq edge %0d: got %0d expected %0d", i, tic_count, seq[i-1]);
        end
      end
      if (pre_tic_enable === 1'b1) begin n_pre++; if (first_pre == 0) first_pre = i; end
      if (tic_enable === 1'b1) begin n_ten++; if (first_ten == 0) first_ten = i; end
      if (accum_enable === 1'b1) n_aen++;
    end
    checks++;
    if (n_pre != 4 || n_ten != 4 || n_aen != 2) begin
      failures++;
      $display("[TB] FAIL basic_counts: got pre=%0d tic=%0d acc=%0d expected 4 4 2", n_pre, n_ten, n_aen);
    end
    checks++;
    if (first_pre != 4 || first_ten != 5) begin
      failures++;
      $display("[TB] FAIL basic_first: got pre@%0d tic@%0d expected pre@4 tic@5", first_pre, first_ten);
    end
  endtask

  task automatic test_divide_change();
    int p1 = 0, p2 = 0, waited = 0;
    while (m_tic != 24'd2 && waited < 12) begin
      cycle(1'b1, 1'b0, 24'd4, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL change_wait_sb: got %h expected %h", got, exp);
      end
      waited++;
    end
    checks++;
    if (m_tic != 24'd2) begin
      failures++;
      $display("[TB] FAIL change_sync: got no count-2 cycle within %0d cycles, required one", waited);
    end
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 24'd7, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL change_sb edge %0d: got %h expected %h", i, got, exp);
      end
      if (pre_tic_enable === 1'b1) begin
        if (p1 == 0) p1 = i;
        else if (p2 == 0) p2 = i;
      end
    end
    checks++;
    if (p1 != 2 || p2 != 10) begin
      failures++;
      $display("[TB] FAIL change_period: got pre@%0d,%0d expected pre@2,10", p1, p2);
    end
  endtask

  task automatic test_divide_zero();
    cycle(1'b1, 1'b1, 24'd0, 24'd9);
    void'(sb.pop_front());
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 1'b0, 24'd0, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL zero_sb edge %0d: got %h expected %h", i, got, exp);
      end
      checks++;
      if (tic_count !== 24'd0 || pre_tic_enable !== 1'b1 || tic_enable !== (i >= 2)) begin
        failures++;
        $display("[TB] FAIL zero_hold edge %0d: got cnt=%0d pre=%b tic=%b expected 0 1 %b",
                 i, tic_count, pre_tic_enable, tic_enable, i >= 2);
      end
    end
  endtask

  task automatic test_sw_rst_accum();
    int waited = 0, first_aen = 0;
    cycle(1'b1, 1'b1, 24'd4, 24'd9);
    void'(sb.pop_front());
    while (m_acc != 24'd1 && waited < 15) begin
      cycle(1'b1, 1'b0, 24'd4, 24'd9);
      void'(sb.pop_front());
      waited++;
    end
    checks++;
    if (accum_count !== 24'd1) begin
      failures++;
      $display("[TB] FAIL swrst_sync: got accum_count=%0d expected 1", accum_count);
    end
    cycle(1'b1, 1'b1, 24'd4, 24'd9);
    void'(sb.pop_front());
    checks++;
    if (accum_count !== 24'd9 || accum_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL swrst_reload: got cnt=%0d en=%b expected 9 0", accum_count, accum_enable);
    end
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b1, 1'b0, 24'd4, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL swrst_sb edge %0d: got %h expected %h", i, got, exp);
      end
      if (accum_enable === 1'b1 && first_aen == 0) first_aen = i;
    end
    checks++;
    if (first_aen != 10) begin
      failures++;
      $display("[TB] FAIL swrst_next_accum: got edge %0d expected edge 10", first_aen);
    end
  endtask

  task automatic test_coincide();
    int both = 0, first_both = 0;
    cycle(1'b1, 1'b1, 24'd3, 24'd7);
    void'(sb.pop_front());
    for (int i = 1; i <= 24; i++) begin
      cycle(1'b1, 1'b0, 24'd3, 24'd7);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL coincide_sb edge %0d: got %h expected %h", i, got, exp);
      end
      if (tic_enable === 1'b1 && accum_enable === 1'b1) begin
        both++;
        if (first_both == 0) first_both = i;
      end
    end
    checks++;
    if (both != 3 || first_both != 8) begin
      failures++;
      $display("[TB] FAIL coincide: got %0d hits first@%0d expected 3 first@8", both, first_both);
    end
  endtask

`ifdef NAMURU_TIME_BASE_PPS_EN
  task automatic test_pps();
    int hits[$];
    cycle(1'b1, 1'b1, 24'd1, 24'd9);
    void'(sb.pop_front());
    for (int i = 1; i <= 50; i++) begin
      cycle(1'b1, 1'b0, 24'd1, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL pps_sb edge %0d: got %h expected %h", i, got, exp);
      end
      if (pps === 1'b1) hits.push_back(i);
    end
    checks++;
    if (hits.size() != 2 || hits[0] != 21 || hits[1] != 41) begin
      failures++;
      $display("[TB] FAIL pps_period: got %0d pulses first@%0d expected 2 at 21,41",
               hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
    hits.delete();
    cycle(1'b0, 1'b0, 24'd1, 24'd9);
    void'(sb.pop_front());
    for (int i = 1; i <= 22; i++) begin
      cycle(1'b1, 1'b0, 24'd1, 24'd9);
      got = {pre_tic_enable, tic_enable, accum_enable, pps_obs, tic_count, accum_count};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL pps_rst_sb edge %0d: got %h expected %h", i, got, exp);
      end
      if (pps === 1'b1) hits.push_back(i);
    end
    checks++;
    if (hits.size() != 1 || hits[0] != 21) begin
      failures++;
      $display("[TB] FAIL pps_restart: got %0d pulses expected 1 at edge 21", hits.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_divide_change();
    test_divide_zero();
    test_sw_rst_accum();
    test_coincide();
`ifdef NAMURU_TIME_BASE_PPS_EN
    test_pps();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
